gauss_filter11: RTL and testbench

Pipelined 11x11 separable Gaussian filter for the SIFT scale-space front end. It sits directly downstream of the 11x11 window extractor and consumes its eleven 88-bit row buses and its start flag. For every window it emits one 8-bit blurred pixel, along with the centre coordinate and a border flag. Border pixels pass through unfiltered, so the next octave/DoG stage receives a full 512x512 frame.

---
 rtl/gauss_filter11_pkg.sv | 29 ++
 rtl/gauss_filter11_fir11_sym.sv | 59 +++++
 rtl/gauss_filter11.sv | 169 ++++++++++++++++
 tb/tb_gauss_filter11.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_filter11_pkg.sv
// Shared constants for the SIFT scale-space Gaussian stage: image geometry,
// pixel/coefficient widths, default kernel taps and the border margin.
package gauss_filter11_pkg;

    localparam int IMG_WIDTH  = 512;
    localparam int IMG_HEIGHT = 512;
    localparam int PIX_W      = 8;
    localparam int COEF_W     = 8;
    localparam int GAUSS_LAT  = 5;
    localparam int BORDER     = 5;
    localparam int NTAPS      = 11;

    localparam logic [COEF_W-1:0] GAUSS_COEF0 = 8'd64;
    localparam logic [COEF_W-1:0] GAUSS_COEF1 = 8'd53;
    localparam logic [COEF_W-1:0] GAUSS_COEF2 = 8'd29;
    localparam logic [COEF_W-1:0] GAUSS_COEF3 = 8'd11;
    localparam logic [COEF_W-1:0] GAUSS_COEF4 = 8'd3;
    localparam logic [COEF_W-1:0] GAUSS_COEF5 = 8'd0;

    typedef logic [8:0] coord_t;

    // True when the window centre lies within BORDER pixels of any edge.
    function automatic logic in_border(input coord_t cx, input coord_t cy,
                                       input int w, input int h);
        return (int'(cx) < BORDER) || (int'(cx) > w - 1 - BORDER) ||
               (int'(cy) < BORDER) || (int'(cy) > h - 1 - BORDER);
    endfunction

endpackage

// File: rtl/gauss_filter11_fir11_sym.sv
// Symmetric 11-tap FIR: register the folded tap pairs, then register the
// full-precision multiply-accumulate. Tap 5 is the centre.
module gauss_fir11_sym
    import gauss_filter11_pkg::*;
#(
    parameter int                DATA_W = PIX_W,
    parameter logic [COEF_W-1:0] COEF0  = GAUSS_COEF0,
    parameter logic [COEF_W-1:0] COEF1  = GAUSS_COEF1,
    parameter logic [COEF_W-1:0] COEF2  = GAUSS_COEF2,
    parameter logic [COEF_W-1:0] COEF3  = GAUSS_COEF3,
    parameter logic [COEF_W-1:0] COEF4  = GAUSS_COEF4,
    parameter logic [COEF_W-1:0] COEF5  = GAUSS_COEF5,
    localparam int               OUT_W  = DATA_W + COEF_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NTAPS*DATA_W-1:0]   taps_i,
    output logic [OUT_W-1:0]          sum_o
);

    localparam logic [5:0][COEF_W-1:0] COEFS = {COEF5, COEF4, COEF3, COEF2, COEF1, COEF0};

    logic [DATA_W-1:0]      ctr_p1_q;
    logic [5:1][DATA_W:0]   fold_p1_q, fold_p1_d;
    logic [OUT_W-1:0]       sum_p2_q, sum_p2_d;

    always_comb begin
        fold_p1_d = '0;
        for (int k = 1; k <= 5; k++) begin
            fold_p1_d[k] = {1'b0, taps_i[(5-k)*DATA_W +: DATA_W]}
                         + {1'b0, taps_i[(5+k)*DATA_W +: DATA_W]};
        end
    end

    // Coefficients sum to 256, so OUT_W bits hold the exact sum.
    always_comb begin
        sum_p2_d = OUT_W'(ctr_p1_q) * OUT_W'(COEFS[0]);
        for (int k = 1; k <= 5; k++) begin
            sum_p2_d = sum_p2_d + OUT_W'(fold_p1_q[k]) * OUT_W'(COEFS[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctr_p1_q  <= '0;
            fold_p1_q <= '0;
            sum_p2_q  <= '0;
        end else begin
            // fold -> p1
            ctr_p1_q  <= taps_i[5*DATA_W +: DATA_W];
            fold_p1_q <= fold_p1_d;
            // MAC -> p2
            sum_p2_q  <= sum_p2_d;
        end
    end

    assign sum_o = sum_p2_q;

endmodule

// File: rtl/gauss_filter11.sv
// 11x11 separable Gaussian blur: eleven column FIRs feed one row FIR, then
// round/saturate with border pass-through and raster coordinate tracking.
module gauss_filter11
    import gauss_filter11_pkg::*;
#(
    parameter int                WIDTH  = IMG_WIDTH,
    parameter int                HEIGHT = IMG_HEIGHT,
    parameter logic [COEF_W-1:0] COEF0  = GAUSS_COEF0,
    parameter logic [COEF_W-1:0] COEF1  = GAUSS_COEF1,
    parameter logic [COEF_W-1:0] COEF2  = GAUSS_COEF2,
    parameter logic [COEF_W-1:0] COEF3  = GAUSS_COEF3,
    parameter logic [COEF_W-1:0] COEF4  = GAUSS_COEF4,
    parameter logic [COEF_W-1:0] COEF5  = GAUSS_COEF5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [87:0] win1,
    input  logic [87:0] win2,
    input  logic [87:0] win3,
    input  logic [87:0] win4,
    input  logic [87:0] win5,
    input  logic [87:0] win6,
    input  logic [87:0] win7,
    input  logic [87:0] win8,
    input  logic [87:0] win9,
    input  logic [87:0] win10,
    input  logic [87:0] win11,
    input  logic        start_flag,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic [8:0]  x,
    output logic [8:0]  y,
    output logic        border,
    output logic        frame_done
);

    localparam int V_W     = PIX_W + COEF_W;
    localparam int H_W     = V_W + COEF_W;
    localparam int HR_W    = H_W + 1;
    localparam int NORM_SH = 2 * COEF_W;
    localparam int RND     = 1 << (NORM_SH - 1);

    function automatic logic [PIX_W-1:0] round_sat(input logic [H_W-1:0] h);
        logic [H_W:0] t;
        t = {1'b0, h} + HR_W'(RND);
        if (|t[H_W:NORM_SH+PIX_W]) return '1;
        return t[NORM_SH+PIX_W-1:NORM_SH];
    endfunction

    logic [10:0][87:0]        rows;
    logic [10:0][87:0]        col_taps;
    logic [10:0][V_W-1:0]     v_p2;
    logic [H_W-1:0]           h_p4;

    assign rows = {win11, win10, win9, win8, win7, win6, win5, win4, win3, win2, win1};

    for (genvar c = 0; c < NTAPS; c++) begin : g_col
        for (genvar j = 0; j < NTAPS; j++) begin : g_tap
            assign col_taps[c][j*PIX_W +: PIX_W] = rows[j][c*PIX_W +: PIX_W];
        end
        gauss_fir11_sym #(
            .DATA_W(PIX_W), .COEF0(COEF0), .COEF1(COEF1), .COEF2(COEF2),
            .COEF3(COEF3), .COEF4(COEF4), .COEF5(COEF5)
        ) u_vfir (
            .clk_i (clk),
            .rst_ni(rst),
            .taps_i(col_taps[c]),
            .sum_o (v_p2[c])
        );
    end

    gauss_fir11_sym #(
        .DATA_W(V_W), .COEF0(COEF0), .COEF1(COEF1), .COEF2(COEF2),
        .COEF3(COEF3), .COEF4(COEF4), .COEF5(COEF5)
    ) u_hfir (
        .clk_i (clk),
        .rst_ni(rst),
        .taps_i(v_p2),
        .sum_o (h_p4)
    );

    logic              vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic [PIX_W-1:0]  ctr_p1_q, ctr_p2_q, ctr_p3_q, ctr_p4_q;
    coord_t            cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    coord_t            x_q, x_d, y_q, y_d;
    logic [PIX_W-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              border_q, border_d;
    logic              frame_done_q, frame_done_d;
    logic              done_now, emit, cnt_at_end;

    // The last pixel sitting in the output register already blocks further output.
    always_comb begin
        done_now     = frame_done_q |
                       (dout_valid_q && x_q == 9'(WIDTH-1) && y_q == 9'(HEIGHT-1));
        emit         = vld_p4_q & ~done_now;
        cnt_at_end   = (cnt_x_q == 9'(WIDTH-1)) && (cnt_y_q == 9'(HEIGHT-1));
        frame_done_d = done_now;
        dout_valid_d = emit;
        cnt_x_d      = cnt_x_q;
        cnt_y_d      = cnt_y_q;
        dout_d       = dout_q;
        x_d          = x_q;
        y_d          = y_q;
        border_d     = border_q;
        if (emit) begin
            border_d = in_border(cnt_x_q, cnt_y_q, WIDTH, HEIGHT);
            dout_d   = border_d ? ctr_p4_q : round_sat(h_p4);
            x_d      = cnt_x_q;
            y_d      = cnt_y_q;
            if (!cnt_at_end) begin
                if (cnt_x_q == 9'(WIDTH-1)) begin
                    cnt_x_d = '0;
                    cnt_y_d = cnt_y_q + 9'd1;
                end else begin
                    cnt_x_d = cnt_x_q + 9'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            vld_p3_q     <= 1'b0;
            vld_p4_q     <= 1'b0;
            ctr_p1_q     <= '0;
            ctr_p2_q     <= '0;
            ctr_p3_q     <= '0;
            ctr_p4_q     <= '0;
            cnt_x_q      <= '0;
            cnt_y_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            border_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // S1..S4: valid and centre pixel track the FIR pipeline
            vld_p1_q     <= start_flag;
            vld_p2_q     <= vld_p1_q;
            vld_p3_q     <= vld_p2_q;
            vld_p4_q     <= vld_p3_q;
            ctr_p1_q     <= win6[5*PIX_W +: PIX_W];
            ctr_p2_q     <= ctr_p1_q;
            ctr_p3_q     <= ctr_p2_q;
            ctr_p4_q     <= ctr_p3_q;
            // S5: output register and coordinate counters
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            border_q     <= border_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign border     = border_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss_filter11.sv
// Scoreboard bench for gauss_filter11 on a reduced 112x108 frame; a second
// instance with custom taps shares the stimulus.
module tb_gauss_filter11;

    localparam int W    = 112;
    localparam int H    = 108;
    localparam int NPIX = W * H;
    localparam int C_A [6] = '{64, 53, 29, 11, 3, 0};
    localparam int C_B [6] = '{56, 48, 30, 14, 6, 2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_flag = 1'b0;
    logic [87:0] win [11];
    logic [7:0]  pix [11][11];
    logic [7:0]  dout, dout_b;
    logic        dout_valid, dout_valid_b, border, border_b, frame_done, frame_done_b;
    logic [8:0]  x, y, x_b, y_b;

    typedef struct {
        logic [7:0] d;
        logic [7:0] d_b;
        logic [8:0] ex;
        logic [8:0] ey;
        logic       bd;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_x = 0, m_y = 0;
    bit   m_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gauss_filter11 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .win1(win[0]), .win2(win[1]), .win3(win[2]), .win4(win[3]),
        .win5(win[4]), .win6(win[5]), .win7(win[6]), .win8(win[7]),
        .win9(win[8]), .win10(win[9]), .win11(win[10]),
        .start_flag(start_flag),
        .dout(dout), .dout_valid(dout_valid), .x(x), .y(y),
        .border(border), .frame_done(frame_done)
    );

    gauss_filter11 #(.WIDTH(W), .HEIGHT(H),
        .COEF0(8'd56), .COEF1(8'd48), .COEF2(8'd30),
        .COEF3(8'd14), .COEF4(8'd6), .COEF5(8'd2)) dut_b (
        .clk(clk), .rst(rst),
        .win1(win[0]), .win2(win[1]), .win3(win[2]), .win4(win[3]),
        .win5(win[4]), .win6(win[5]), .win7(win[6]), .win8(win[7]),
        .win9(win[8]), .win10(win[9]), .win11(win[10]),
        .start_flag(start_flag),
        .dout(dout_b), .dout_valid(dout_valid_b), .x(x_b), .y(y_b),
        .border(border_b), .frame_done(frame_done_b)
    );

    // Direct 2-D convolution over the whole window.
    function automatic logic [7:0] model(input bit use_b);
        longint acc = 0;
        int dr, dc, kr, kc;
        for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
                dr = (r > 5) ? r - 5 : 5 - r;
                dc = (c > 5) ? c - 5 : 5 - c;
                kr = use_b ? C_B[dr] : C_A[dr];
                kc = use_b ? C_B[dc] : C_A[dc];
                acc += longint'(kr) * longint'(kc) * longint'(pix[r][c]);
            end
        end
        acc = (acc + 32768) >> 16;
        return (acc > 255) ? 8'd255 : acc[7:0];
    endfunction

    task automatic fill_flat(input int v);
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) pix[r][c] = 8'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) pix[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_impulse(input int v);
        fill_flat(0);
        pix[5][5] = 8'(v);
    endtask

    task automatic drive(input bit sf);
        exp_t e;
        @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 11; c++) win[r][c*8 +: 8] = pix[r][c];
        start_flag = sf;
        if (sf && !m_done) begin
            e.bd  = (m_x < 5) || (m_x >= W - 5) || (m_y < 5) || (m_y >= H - 5);
            e.d   = e.bd ? pix[5][5] : model(1'b0);
            e.d_b = e.bd ? pix[5][5] : model(1'b1);
            e.ex  = 9'(m_x);
            e.ey  = 9'(m_y);
            e.cyc = cyc;
            sb.push_back(e);
            if (m_x == W - 1 && m_y == H - 1) m_done = 1'b1;
            else if (m_x == W - 1) begin m_x = 0; m_y++; end
            else m_x++;
        end
    endtask

    task automatic do_reset();
        start_flag = 1'b0;
        rst = 1'b0;
        sb.delete();
        m_x = 0; m_y = 0; m_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_pix(input int tx, input int ty, output bit found);
        found = 1'b0;
        for (int i = 0; i < NPIX + 200 && !found; i++) begin
            @(negedge clk);
            if (dout_valid === 1'b1 && int'(x) == tx && int'(y) == ty) found = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (dout_valid_b !== dout_valid) begin
                n_fail++;
                $display("FAIL valid_b: got %b required %b", dout_valid_b, dout_valid);
            end
            if (dout_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL extra_output: got valid at x=%0d y=%0d required none", x, y);
                end else begin
                    mon_e = sb.pop_front();
                    n_checks++;
                    if (dout !== mon_e.d) begin n_fail++;
                        $display("FAIL sb_dout (%0d,%0d): got %0d required %0d", mon_e.ex, mon_e.ey, dout, mon_e.d); end
                    n_checks++;
                    if (dout_b !== mon_e.d_b) begin n_fail++;
                        $display("FAIL sb_dout_b (%0d,%0d): got %0d required %0d", mon_e.ex, mon_e.ey, dout_b, mon_e.d_b); end
                    n_checks++;
                    if (x !== mon_e.ex || y !== mon_e.ey) begin n_fail++;
                        $display("FAIL sb_xy: got (%0d,%0d) required (%0d,%0d)", x, y, mon_e.ex, mon_e.ey); end
                    n_checks++;
                    if (border !== mon_e.bd) begin n_fail++;
                        $display("FAIL sb_border (%0d,%0d): got %b required %b", mon_e.ex, mon_e.ey, border, mon_e.bd); end
                    n_checks++;
                    if (cyc - mon_e.cyc != 5) begin n_fail++;
                        $display("FAIL sb_latency: got %0d required 5", cyc - mon_e.cyc); end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (dout !== 8'd0 || dout_valid !== 1'b0 || x !== 9'd0 || y !== 9'd0 ||
            border !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got dout=%0d v=%b x=%0d y=%0d b=%b fd=%b required all 0",
                     dout, dout_valid, x, y, border, frame_done);
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_flat();
        int t0; bit got; bit found;
        do_reset();
        fill_flat(100);
        drive(1'b1);
        t0 = cyc;
        fork
            begin
                for (int i = 1; i < 700; i++) drive(1'b1);
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 40 && !got; i++) begin
                    @(negedge clk);
                    if (dout_valid === 1'b1) got = 1'b1;
                end
                n_checks++;
                if (!got || cyc - t0 != 5) begin n_fail++;
                    $display("FAIL flat_latency: got %0d required 5", got ? cyc - t0 : -1); end
                n_checks++;
                if (dout !== 8'd100) begin n_fail++;
                    $display("FAIL flat_first: got %0d required 100", dout); end
                wait_pix(50, 5, found);
                n_checks++;
                if (!found || dout !== 8'd100 || border !== 1'b0) begin n_fail++;
                    $display("FAIL flat_interior: got dout=%0d border=%b found=%b required 100/0", dout, border, found); end
            end
        join
        repeat (10) drive(1'b0);
        n_checks++;
        if (sb.size() != 0) begin n_fail++;
            $display("FAIL flat_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_frame();
        logic [7:0] ctr0; bit found;
        do_reset();
        fill_rand();
        ctr0 = pix[5][5];
        drive(1'b1);
        fork
            begin
                for (int i = 1; i < NPIX; i++) begin
                    if (i == 5*W + 4 || i == 5*W + 5 || i == 100*W + 100) fill_impulse(255);
                    else if (i == 50*W + 50) fill_flat(255);
                    else fill_rand();
                    drive(1'b1);
                end
                repeat (20) drive(1'b1);
            end
            begin
                wait_pix(0, 0, found);
                n_checks++;
                if (!found || border !== 1'b1 || dout !== ctr0) begin n_fail++;
                    $display("FAIL border_first: got dout=%0d border=%b required %0d/1", dout, border, ctr0); end
                wait_pix(4, 5, found);
                n_checks++;
                if (!found || border !== 1'b1 || dout !== 8'd255) begin n_fail++;
                    $display("FAIL border_4_5: got dout=%0d border=%b required 255/1", dout, border); end
                wait_pix(5, 5, found);
                n_checks++;
                if (!found || border !== 1'b0 || dout !== 8'd16) begin n_fail++;
                    $display("FAIL interior_5_5: got dout=%0d border=%b required 16/0", dout, border); end
                wait_pix(50, 50, found);
                n_checks++;
                if (!found || dout !== 8'd255 || dout_b !== 8'd255) begin n_fail++;
                    $display("FAIL saturation: got %0d/%0d required 255/255", dout, dout_b); end
                wait_pix(100, 100, found);
                n_checks++;
                if (!found || dout !== 8'd16) begin n_fail++;
                    $display("FAIL impulse: got %0d required 16", dout); end
                wait_pix(W - 1, H - 1, found);
                n_checks++;
                if (!found || frame_done !== 1'b0) begin n_fail++;
                    $display("FAIL last_pixel: got found=%b frame_done=%b required 1/0", found, frame_done); end
                repeat (10) begin
                    @(negedge clk);
                    n_checks++;
                    if (frame_done !== 1'b1 || dout_valid !== 1'b0) begin n_fail++;
                        $display("FAIL frame_done_hold: got fd=%b v=%b required 1/0", frame_done, dout_valid); end
                end
            end
        join
        drive(1'b0);
        n_checks++;
        if (sb.size() != 0) begin n_fail++;
            $display("FAIL frame_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_dropout();
        do_reset();
        for (int i = 0; i < 150; i++) begin fill_rand(); drive(1'b1); end
        repeat (7) drive(1'b0);
        @(negedge clk);
        n_checks++;
        if (dout_valid !== 1'b0 || x !== 9'd37 || y !== 9'd1) begin n_fail++;
            $display("FAIL dropout_hold: got v=%b x=%0d y=%0d required 0/37/1", dout_valid, x, y); end
        for (int i = 0; i < 150; i++) begin fill_rand(); drive(1'b1); end
        repeat (10) drive(1'b0);
        n_checks++;
        if (sb.size() != 0) begin n_fail++;
            $display("FAIL dropout_drain: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int t0; bit got;
        do_reset();
        for (int i = 0; i < 1000; i++) begin fill_rand(); drive(1'b1); end
        n_checks++;
        if (dout_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset_valid: got %b required 1", dout_valid); end
        #1 rst = 1'b0;
        sb.delete();
        m_x = 0; m_y = 0; m_done = 1'b0;
        #1;
        n_checks++;
        if (dout !== 8'd0 || dout_valid !== 1'b0 || x !== 9'd0 || y !== 9'd0 ||
            border !== 1'b0 || frame_done !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset: got dout=%0d v=%b x=%0d y=%0d b=%b fd=%b required all 0",
                     dout, dout_valid, x, y, border, frame_done); end
        start_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        fill_rand();
        drive(1'b1);
        t0 = cyc;
        fork
            begin
                for (int i = 0; i < 20; i++) begin fill_rand(); drive(1'b1); end
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 40 && !got; i++) begin
                    @(negedge clk);
                    if (dout_valid === 1'b1) got = 1'b1;
                end
                n_checks++;
                if (!got || cyc - t0 != 5 || x !== 9'd0 || y !== 9'd0) begin n_fail++;
                    $display("FAIL restart: got lat=%0d x=%0d y=%0d required 5/0/0", got ? cyc - t0 : -1, x, y); end
            end
        join
        repeat (10) drive(1'b0);
        n_checks++;
        if (sb.size() != 0) begin n_fail++;
            $display("FAIL restart_drain: got %0d pending required 0", sb.size()); end
    endtask

    initial begin
        fill_flat(0);
        for (int r = 0; r < 11; r++) win[r] = '0;
        test_reset();
        test_flat();
        test_frame();
        test_dropout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
